// File: rtl/shift_pkg.sv
// shift_pkg: shared opcode/state types and defaults for the bit-serial shift engine.
package shift_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LSL  = 3'b001,
        OP_ASL  = 3'b010,
        OP_LSR  = 3'b011,
        OP_ASR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_RSVD = 3'b111
    } shift_op_e;

    typedef enum logic {IDLE, RUN} state_e;

    function automatic logic op_moves(shift_op_e op);
        return !(op inside {OP_NOP, OP_RSVD});
    endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-bit shift/rotate step with the expelled bit.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] next_word,
    output logic             bit_out
);

    always_comb begin
        next_word = word;
        bit_out   = 1'b0;
        case (shift_op_e'(op))
            OP_LSL, OP_ASL: begin
                next_word = {word[WIDTH-2:0], 1'b0};
                bit_out   = word[WIDTH-1];
            end
            OP_LSR: begin
                next_word = {1'b0, word[WIDTH-1:1]};
                bit_out   = word[0];
            end
            OP_ASR: begin
                next_word = {word[WIDTH-1], word[WIDTH-1:1]};
                bit_out   = word[0];
            end
            OP_ROL: begin
                next_word = {word[WIDTH-2:0], word[WIDTH-1]};
                bit_out   = word[WIDTH-1];
            end
            OP_ROR: begin
                next_word = {word[0], word[WIDTH-1:1]};
                bit_out   = word[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_shift_engine.sv
// serial_shift_engine: captures an operand and opcode on start, then applies one
// 1-bit shift/rotate step per clock for shift_count cycles.
module serial_shift_engine
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] d_in,
    input  logic [2:0]              sel,
    input  logic [CNT_W-1:0]        shift_count,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] d_out,
    output logic                    shift_bit_out,
    output logic                    step_valid
);

    state_e            state, state_n;
    shift_op_e         op, op_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [WIDTH-1:0]  d_n, step_word;
    logic              bit_n, step_bit, busy_n, done_n, sv_n;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op       (op),
        .word     (d_out),
        .next_word(step_word),
        .bit_out  (step_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op            <= OP_NOP;
            cnt           <= '0;
            d_out         <= '0;
            shift_bit_out <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            step_valid    <= 1'b0;
        end else begin
            state         <= state_n;
            op            <= op_n;
            cnt           <= cnt_n;
            d_out         <= d_n;
            shift_bit_out <= bit_n;
            busy          <= busy_n;
            done          <= done_n;
            step_valid    <= sv_n;
        end
    end

    // In IDLE, busy=1 marks a zero-work operation whose done is due on this edge.
    always_comb begin
        state_n = state;
        op_n    = op;
        cnt_n   = cnt;
        d_n     = d_out;
        bit_n   = shift_bit_out;
        busy_n  = busy;
        done_n  = 1'b0;
        sv_n    = 1'b0;
        case (state)
            IDLE: begin
                if (busy) begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end else if (start) begin
                    d_n     = d_in;
                    op_n    = shift_op_e'(sel);
                    cnt_n   = shift_count;
                    bit_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = (shift_count != '0 && op_moves(shift_op_e'(sel))) ? RUN : IDLE;
                end
            end
            RUN: begin
                d_n   = step_word;
                bit_n = step_bit;
                cnt_n = cnt - CNT_W'(1);
                sv_n  = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_shift_engine.sv
// tb_serial_shift_engine: directed vectors plus a queue-based reference model checked every cycle.
module tb_serial_shift_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic [2:0] sel = 3'd0;
    logic [2:0] shift_count = 3'd0;
    logic       busy, done, shift_bit_out, step_valid;
    logic [7:0] d_out;

    int errors = 0;
    int checks = 0;

    serial_shift_engine #(.WIDTH(8), .CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .d_in         (d_in),
        .sel          (sel),
        .shift_count  (shift_count),
        .busy         (busy),
        .done         (done),
        .d_out        (d_out),
        .shift_bit_out(shift_bit_out),
        .step_valid   (step_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each accepted op becomes a queue of {bit, word} results, one per step.
    logic [8:0] q[$];
    logic [7:0] m_word;
    logic       m_bit, m_busy, m_done, m_sv;

    function automatic logic [8:0] ref_step(logic [2:0] op, logic [7:0] w);
        case (op)
            3'd1, 3'd2: return {w[7], w << 1};
            3'd3:       return {w[0], w >> 1};
            3'd4:       return {w[0], 8'($signed(w) >>> 1)};
            3'd5:       return {w[7], (w << 1) | (w >> 7)};
            3'd6:       return {w[0], (w >> 1) | (w << 7)};
            default:    return {1'b0, w};
        endcase
    endfunction

    function automatic void build(logic [2:0] op, logic [7:0] d, int n);
        logic [7:0] w = d;
        logic [8:0] r;
        if (op == 3'd0 || op == 3'd7) return;
        for (int i = 0; i < n; i++) begin
            r = ref_step(op, w);
            q.push_back(r);
            w = r[7:0];
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_word <= 8'h00;
            m_bit  <= 1'b0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sv   <= 1'b0;
            q.delete();
        end else begin
            m_done <= 1'b0;
            m_sv   <= 1'b0;
            if (m_busy) begin
                if (q.size() == 0) begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end else begin
                    {m_bit, m_word} <= q.pop_front();
                    m_sv <= 1'b1;
                    if (q.size() == 0) begin
                        m_done <= 1'b1;
                        m_busy <= 1'b0;
                    end
                end
            end else if (start) begin
                m_word <= d_in;
                m_bit  <= 1'b0;
                m_busy <= 1'b1;
                build(sel, d_in, int'(shift_count));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("step_valid", 32'(step_valid), 32'(m_sv));
        chk("d_out", 32'(d_out), 32'(m_word));
        chk("shift_bit_out", 32'(shift_bit_out), 32'(m_bit));
    end

    task automatic run(string nm, logic [2:0] op, logic [7:0] d, logic [2:0] n,
                       logic [7:0] ed, logic eb, int el, int es, logic [7:0] ebits);
        int lat = 0, steps = 0, bsy = 0;
        logic [7:0] bits = 8'h00;
        @(negedge clk);
        start = 1'b1; sel = op; d_in = d; shift_count = n;
        @(posedge clk); #1;
        start = 1'b0; d_in = ~d; sel = ~op; shift_count = ~n;
        while (!done && lat < 40) begin
            if (busy) bsy++;
            @(posedge clk); #1;
            lat++;
            if (step_valid) begin
                steps++;
                bits = {bits[6:0], shift_bit_out};
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'(el));
        chk({nm, " busy_cycles"}, 32'(bsy), 32'(el));
        chk({nm, " d_out"}, 32'(d_out), 32'(ed));
        chk({nm, " bit_out"}, 32'(shift_bit_out), 32'(eb));
        chk({nm, " steps"}, 32'(steps), 32'(es));
        chk({nm, " step_bits"}, 32'(bits), 32'(ebits));
    endtask

    initial begin
        int lat, dn;
        repeat (3) @(negedge clk);
        chk("reset d_out", 32'(d_out), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        rst = 1'b0;

        run("ASR", 3'd4, 8'h96, 3'd3, 8'hF2, 1'b1, 3, 3, 8'h03);
        run("ROL", 3'd5, 8'h96, 3'd3, 8'hB4, 1'b0, 3, 3, 8'h04);
        run("ROR", 3'd6, 8'h96, 3'd7, 8'h2D, 1'b0, 7, 7, 8'h34);
        run("LSL", 3'd1, 8'h96, 3'd2, 8'h58, 1'b0, 2, 2, 8'h02);
        run("ASL", 3'd2, 8'h96, 3'd2, 8'h58, 1'b0, 2, 2, 8'h02);
        run("LSR0", 3'd3, 8'h96, 3'd0, 8'h96, 1'b0, 1, 0, 8'h00);
        run("RSVD", 3'd7, 8'h96, 3'd5, 8'h96, 1'b0, 1, 0, 8'h00);

        // Start pulsed mid-operation must be ignored.
        @(negedge clk);
        start = 1'b1; sel = 3'd3; d_in = 8'hFF; shift_count = 3'd5;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; sel = 3'd1; d_in = 8'h00; shift_count = 3'd1;
        @(negedge clk); start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_protect d_out", 32'(d_out), 32'h07);
        chk("busy_protect bit_out", 32'(shift_bit_out), 32'h1);
        // Next start is raised while done is still high.
        run("b2b ASL", 3'd2, 8'h81, 3'd1, 8'h02, 1'b1, 1, 1, 8'h01);

        // Reset mid-operation aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; sel = 3'd6; d_in = 8'h96; shift_count = 3'd6;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort d_out", 32'(d_out), 32'h0);
        chk("abort busy", 32'(busy), 32'h0);
        @(negedge clk); rst = 1'b0;
        dn = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("abort no_done", 32'(dn), 32'h0);
        run("ROL after rst", 3'd5, 8'h01, 3'd1, 8'h02, 1'b0, 1, 1, 8'h00);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
